// File: rtl/elevador_pkg.sv
// Shared types and constants for the elevator control unit and its datapath.
package elevador_pkg;

  localparam int unsigned MaxParadasDefault = 16;
  localparam int unsigned AndarW            = 4;

  // State codes are visible on db_estado, so the encoding is fixed.
  typedef enum logic [3:0] {
    Inicial       = 4'd0,
    Espera        = 4'd1,
    EnfilaOrigem  = 4'd2,
    EnfilaDestino = 4'd3,
    Verifica      = 4'd4,
    Movendo       = 4'd5,
    Atualiza      = 4'd6,
    PortaAberta   = 4'd7,
    Remove        = 4'd8
  } estado_t;

endpackage

// File: rtl/uc_gerenciador_elevador_if.sv
// Signal bundle between the elevator control unit (master) and its datapath (slave).
interface uc_gerenciador_elevador_if;
  import elevador_pkg::*;

  logic              bordaNovaEntrada;
  logic              chegouDestino;
  logic              fimT;
  logic [AndarW-1:0] proxParada;
  logic [AndarW-1:0] andarAtual;

  logic              shift;
  logic              enableRAM;
  logic              enableTopRAM;
  logic              select1;
  logic              select2;
  logic              zeraT;
  logic              contaT;
  logic              clearAndarAtual;
  logic              clearSuperRam;
  logic              enableAndarAtual;

  logic              em_movimento;
  logic              porta_aberta;
  logic              fila_vazia;
  logic              erro_fila;
  logic [3:0]        db_estado;

  modport master (
    input  bordaNovaEntrada, chegouDestino, fimT, proxParada, andarAtual,
    output shift, enableRAM, enableTopRAM, select1, select2, zeraT, contaT,
           clearAndarAtual, clearSuperRam, enableAndarAtual,
           em_movimento, porta_aberta, fila_vazia, erro_fila, db_estado
  );

  modport slave (
    output bordaNovaEntrada, chegouDestino, fimT, proxParada, andarAtual,
    input  shift, enableRAM, enableTopRAM, select1, select2, zeraT, contaT,
           clearAndarAtual, clearSuperRam, enableAndarAtual,
           em_movimento, porta_aberta, fila_vazia, erro_fila, db_estado
  );

endinterface

// File: rtl/uc_gerenciador_elevador_contador_fila.sv
// Occupancy counter for the stop queue: tracks entries pushed minus entries popped.
module contador_fila #(
  parameter int unsigned MAX_PARADAS = 16,
  parameter int unsigned OcupW       = $clog2(MAX_PARADAS + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic incrementa,
  input  logic decrementa,
  output logic vazia,
  output logic cheia
);

  localparam logic [OcupW-1:0] OcupMax   = OcupW'(MAX_PARADAS);
  // A request needs two free slots; above this level one more request would overflow.
  localparam logic [OcupW-1:0] OcupLimia = OcupW'(MAX_PARADAS - 2);

  logic [OcupW-1:0] ocupacaoQ, ocupacaoD;

  // Next count: saturates at both ends so it can never wrap.
  always_comb begin
    ocupacaoD = ocupacaoQ;
    if (clear) begin
      ocupacaoD = '0;
    end else if (incrementa && !decrementa && ocupacaoQ != OcupMax) begin
      ocupacaoD = ocupacaoQ + 1'b1;
    end else if (decrementa && !incrementa && ocupacaoQ != '0) begin
      ocupacaoD = ocupacaoQ - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      ocupacaoQ <= '0;
    end else begin
      ocupacaoQ <= ocupacaoD;
    end
  end

  // Status flags.
  always_comb begin
    vazia = (ocupacaoQ == '0);
    cheia = (ocupacaoQ > OcupLimia);
  end

endmodule

// File: rtl/uc_gerenciador_elevador.sv
// Elevator control unit: sequences queue pushes/pops, floor moves and door timing on the FD.
module uc_gerenciador_elevador
  import elevador_pkg::*;
#(
  parameter int unsigned MAX_PARADAS  = MaxParadasDefault,
  parameter int unsigned PULSOS_PORTA = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  uc_gerenciador_elevador_if.master  fd
);

  localparam int unsigned PortaW = $clog2(PULSOS_PORTA + 1);
  localparam logic [PortaW-1:0] PortaUltimo = PortaW'(PULSOS_PORTA - 1);

  estado_t           estadoQ, estadoD;
  estado_t           retornoQ, retornoD;
  logic              sobeQ, sobeD;
  logic [PortaW-1:0] cntPortaQ, cntPortaD;
  logic              erroQ, erroD;

  logic filaVazia, filaCheia;
  logic pushFila, popFila;

  contador_fila #(
    .MAX_PARADAS (MAX_PARADAS)
  ) uContadorFila (
    .clock      (clock),
    .reset      (reset),
    .clear      (estadoQ == Inicial),
    .incrementa (pushFila),
    .decrementa (popFila),
    .vazia      (filaVazia),
    .cheia      (filaCheia)
  );

  // Next-state, bookkeeping registers and Moore control outputs.
  always_comb begin
    estadoD  = estadoQ;
    retornoD = retornoQ;
    sobeD    = sobeQ;
    cntPortaD = cntPortaQ;
    erroD    = 1'b0;

    pushFila            = 1'b0;
    popFila             = 1'b0;
    fd.select1          = 1'b0;
    fd.select2          = 1'b0;
    fd.zeraT            = 1'b0;
    fd.contaT           = 1'b0;
    fd.clearAndarAtual  = 1'b0;
    fd.clearSuperRam    = 1'b0;
    fd.enableAndarAtual = 1'b0;

    case (estadoQ)
      Inicial: begin
        fd.clearAndarAtual = 1'b1;
        fd.clearSuperRam   = 1'b1;
        fd.zeraT           = 1'b1;
        estadoD            = Espera;
      end
      Espera: begin
        if (fd.bordaNovaEntrada) begin
          if (filaCheia) begin
            erroD = 1'b1;
          end else begin
            estadoD  = EnfilaOrigem;
            retornoD = Verifica;
          end
        end else if (!filaVazia) begin
          estadoD = Verifica;
        end
      end
      EnfilaOrigem: begin
        pushFila   = 1'b1;
        fd.select1 = 1'b1;
        estadoD    = EnfilaDestino;
      end
      EnfilaDestino: begin
        pushFila = 1'b1;
        estadoD  = retornoQ;
      end
      Verifica: begin
        fd.zeraT = 1'b1;
        if (fd.chegouDestino) begin
          estadoD   = PortaAberta;
          cntPortaD = '0;
        end else begin
          // Only reached with head != floor, so the chosen direction never wraps the floor.
          sobeD   = (fd.proxParada > fd.andarAtual);
          estadoD = Movendo;
        end
      end
      Movendo: begin
        fd.contaT = 1'b1;
        // A new request takes priority over a simultaneous timer expiry.
        if (fd.bordaNovaEntrada) begin
          if (filaCheia) begin
            erroD = 1'b1;
          end else begin
            estadoD  = EnfilaOrigem;
            retornoD = Movendo;
          end
        end else if (fd.fimT) begin
          estadoD = Atualiza;
        end
      end
      Atualiza: begin
        fd.enableAndarAtual = 1'b1;
        fd.select2          = sobeQ;
        fd.zeraT            = 1'b1;
        estadoD             = Verifica;
      end
      PortaAberta: begin
        fd.contaT = 1'b1;
        if (fd.bordaNovaEntrada) begin
          if (filaCheia) begin
            erroD = 1'b1;
          end else begin
            estadoD  = EnfilaOrigem;
            retornoD = PortaAberta;
          end
        end else if (fd.fimT) begin
          cntPortaD = cntPortaQ + 1'b1;
          if (cntPortaQ == PortaUltimo) begin
            estadoD = Remove;
          end
        end
      end
      Remove: begin
        popFila  = 1'b1;
        fd.zeraT = 1'b1;
        estadoD  = Espera;
      end
      default: begin
        estadoD = Inicial;
      end
    endcase

    fd.shift        = popFila;
    fd.enableRAM    = pushFila;
    fd.enableTopRAM = 1'b0;
    fd.em_movimento = (estadoQ == Movendo) || (estadoQ == Atualiza);
    fd.porta_aberta = (estadoQ == PortaAberta);
    fd.fila_vazia   = filaVazia;
    fd.erro_fila    = erroQ;
    fd.db_estado    = estadoQ;
  end

  // State and bookkeeping registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      estadoQ   <= Inicial;
      retornoQ  <= Verifica;
      sobeQ     <= 1'b0;
      cntPortaQ <= '0;
      erroQ     <= 1'b0;
    end else begin
      estadoQ   <= estadoD;
      retornoQ  <= retornoD;
      sobeQ     <= sobeD;
      cntPortaQ <= cntPortaD;
      erroQ     <= erroD;
    end
  end

endmodule
